fixed_decoder_order2: RTL

//   Order-2 FLAC fixed-predictor decoder; inverse of the order-2 fixed encoder.

---
 rtl/fixed_decoder_order2_pkg.sv | 22 ++
 rtl/fixed_decoder_order2_if.sv | 36 +++
 rtl/fixed_decoder_order2.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/fixed_decoder_order2_pkg.sv
// ---------------------------------------------------------------------------
// fixed_decoder_order2_pkg
//   Shared definitions for the order-2 fixed-predictor decoder: default
//   sample and block-size widths, the predictor order, and the control
//   state encoding.
//   Ports: none (package).
// ---------------------------------------------------------------------------
package fixed_decoder_order2_pkg;

    localparam int DEF_SAMPLE_W = 16;
    localparam int DEF_BLK_W    = 16;

    // Number of verbatim warm-up samples at the start of every block.
    localparam int FIXED_ORDER  = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WARMUP = 2'd1,
        S_DECODE = 2'd2
    } state_e;

endpackage

// File: rtl/fixed_decoder_order2_if.sv
// ---------------------------------------------------------------------------
// fixed_decoder_order2_if
//   Bundles the decoder's block-control, input-word and output-sample
//   signals.
//   master modport: the upstream residual source / PCM sink side
//     drives iStart, iBlockSize, iValid, iData
//     sees   oValid, oSample, oBlockDone, oBusy
//   slave modport: the decoder itself (directions mirrored).
// ---------------------------------------------------------------------------
interface fixed_decoder_order2_if
    import fixed_decoder_order2_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int BLK_W    = DEF_BLK_W
);

    logic                iStart;
    logic [BLK_W-1:0]    iBlockSize;
    logic                iValid;
    logic [SAMPLE_W-1:0] iData;
    logic                oValid;
    logic [SAMPLE_W-1:0] oSample;
    logic                oBlockDone;
    logic                oBusy;

    modport master (
        output iStart, iBlockSize, iValid, iData,
        input  oValid, oSample, oBlockDone, oBusy
    );

    modport slave (
        input  iStart, iBlockSize, iValid, iData,
        output oValid, oSample, oBlockDone, oBusy
    );

endinterface

// File: rtl/fixed_decoder_order2.sv
// ---------------------------------------------------------------------------
// fixed_decoder_order2
//   Order-2 fixed-predictor decoder. Each block starts with two verbatim
//   warm-up samples followed by residuals; samples are rebuilt with
//   x[n] = r[n] + 2*x[n-1] - x[n-2], all modulo 2^SAMPLE_W.
//   Ports:
//     iClock    rising-edge clock
//     iReset_n  asynchronous active-low reset
//     bus       slave side of fixed_decoder_order2_if
//               (iStart/iBlockSize/iValid/iData in,
//                oValid/oSample/oBlockDone/oBusy out)
//   Throughput one sample per clock; a word accepted at edge t appears on
//   oValid/oSample after edge t+2.
// ---------------------------------------------------------------------------
module fixed_decoder_order2
    import fixed_decoder_order2_pkg::*;
#(
    parameter int SAMPLE_W = DEF_SAMPLE_W,
    parameter int BLK_W    = DEF_BLK_W
) (
    input  logic                  iClock,
    input  logic                  iReset_n,
    fixed_decoder_order2_if.slave bus
);

    localparam logic [BLK_W-1:0] ORDER_CNT = BLK_W'(FIXED_ORDER);
    localparam logic [BLK_W-1:0] CNT_ONE   = BLK_W'(1);

    // Control state
    state_e              state_q, state_d;
    logic [BLK_W-1:0]    cnt_q, cnt_d;
    logic [BLK_W-1:0]    size_q, size_d;

    // Effective view of this cycle once a (non-empty) iStart is applied
    logic                startOk;
    state_e              effState;
    logic [BLK_W-1:0]    effCnt;
    logic [BLK_W-1:0]    effSize;
    logic [BLK_W-1:0]    cntNext;
    logic                accept;
    logic                lastWord;
    logic                warmWord;

    // Stage 0: registered input word plus its phase tags
    logic                s0Valid_q;
    logic [SAMPLE_W-1:0] s0Data_q;
    logic                s0Warm_q;
    logic                s0Last_q;

    // Stage 1: history registers (x1 is also the freshly decoded sample)
    logic [SAMPLE_W-1:0] x1_q;
    logic [SAMPLE_W-1:0] x2_q;
    logic                s1Valid_q;
    logic                s1Last_q;
    logic [SAMPLE_W-1:0] sample;

    // Output registers
    logic                oValid_q;
    logic [SAMPLE_W-1:0] oSample_q;
    logic                oBlockDone_q;

    // A start with a non-zero size restarts the block in the same cycle, so a
    // word arriving alongside iStart is treated as the new block's first
    // warm-up sample. The counter tells warm-up from residual and spots the
    // last word so its done tag can travel down the pipeline with it.
    always_comb begin
        startOk  = bus.iStart && (bus.iBlockSize != '0);
        effState = startOk ? S_WARMUP : state_q;
        effCnt   = startOk ? '0 : cnt_q;
        effSize  = startOk ? bus.iBlockSize : size_q;
        accept   = bus.iValid && (effState != S_IDLE);
        cntNext  = effCnt + CNT_ONE;
        lastWord = (cntNext == effSize);
        warmWord = (effCnt < ORDER_CNT);

        state_d  = effState;
        cnt_d    = effCnt;
        size_d   = effSize;
        if (accept) begin
            cnt_d = cntNext;
            if (lastWord) begin
                state_d = S_IDLE;
            end else if (cntNext >= ORDER_CNT) begin
                state_d = S_DECODE;
            end else begin
                state_d = S_WARMUP;
            end
        end
    end

    // Control registers: state, accepted-word counter and latched block size.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
        end
    end

    // The prediction 2*x1 - x2 is kept at SAMPLE_W bits on purpose: the
    // encoder's residual wrapped the same way, so wrapping here inverts it
    // exactly. The shift is a plain rewire, leaving one add/sub level in the
    // x1/x2 feedback loop.
    always_comb begin
        sample = s0Data_q;
        if (!s0Warm_q) begin
            sample = s0Data_q + {x1_q[SAMPLE_W-2:0], 1'b0} - x2_q;
        end
    end

    // Datapath: stage 0 captures accepted words, stage 1 updates history, and
    // the output stage presents the sample two edges after acceptance.
    // History only moves on a valid word, so bubbles leave it untouched.
    always_ff @(posedge iClock or negedge iReset_n) begin
        if (!iReset_n) begin
            s0Valid_q    <= 1'b0;
            s0Data_q     <= '0;
            s0Warm_q     <= 1'b0;
            s0Last_q     <= 1'b0;
            x1_q         <= '0;
            x2_q         <= '0;
            s1Valid_q    <= 1'b0;
            s1Last_q     <= 1'b0;
            oValid_q     <= 1'b0;
            oSample_q    <= '0;
            oBlockDone_q <= 1'b0;
        end else begin
            s0Valid_q <= accept;
            if (accept) begin
                s0Data_q <= bus.iData;
                s0Warm_q <= warmWord;
                s0Last_q <= lastWord;
            end

            s1Valid_q <= s0Valid_q;
            s1Last_q  <= s0Valid_q && s0Last_q;
            if (s0Valid_q) begin
                x1_q <= sample;
                x2_q <= x1_q;
            end

            oValid_q     <= s1Valid_q;
            oBlockDone_q <= s1Last_q;
            if (s1Valid_q) begin
                oSample_q <= x1_q;
            end
        end
    end

    assign bus.oValid     = oValid_q;
    assign bus.oSample    = oSample_q;
    assign bus.oBlockDone = oBlockDone_q;
    assign bus.oBusy      = (state_q != S_IDLE);

endmodule
